// File: rtl/sim_command_unit_pkg.sv
// Shared definitions for the keyboard command front end: HID usage codes,
// the command FSM state type and the per-key press-event bundle.
package sim_command_unit_pkg;

  // HID usage codes of the keys the simulation reacts to
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_R     = 8'h15;
  localparam logic [7:0] KEY_EQ    = 8'h2E;
  localparam logic [7:0] KEY_MINUS = 8'h2D;

  // Highest speed level; level 0 is the slowest
  localparam logic [2:0] MAX_LEVEL = 3'd7;

  typedef enum logic [1:0] {
    ST_PAUSED    = 2'd0,
    ST_RUNNING   = 2'd1,
    ST_STEPPING  = 2'd2,
    ST_RESETTING = 2'd3
  } sim_cmd_state_t;

  // One bit per recognised key
  typedef struct packed {
    logic space;
    logic step;
    logic reset;
    logic faster;
    logic slower;
  } key_events_t;

  // True when either byte of the keycode carries the given usage code
  function automatic logic code_has_key(input logic [15:0] code, input logic [7:0] key);
    return (code[15:8] == key) || (code[7:0] == key);
  endfunction

  // Which recognised keys are down in a keycode, regardless of byte order
  function automatic key_events_t decode_keys(input logic [15:0] code);
    key_events_t k;
    k.space  = code_has_key(code, KEY_SPACE);
    k.step   = code_has_key(code, KEY_S);
    k.reset  = code_has_key(code, KEY_R);
    k.faster = code_has_key(code, KEY_EQ);
    k.slower = code_has_key(code, KEY_MINUS);
    return k;
  endfunction

endpackage

// File: rtl/sim_command_unit_debouncer.sv
// Keycode debouncer. A keycode is accepted once it has been sampled unchanged
// for DEBOUNCE_CYCLES consecutive cycles; on acceptance, every recognised key
// that is down in the new code but was not down in the previous accepted code
// produces a one-cycle press strobe. Strobes are fire-and-forget: there is no
// ready/backpressure, the consumer must act on the cycle the strobe is high.
module key_debouncer
  import sim_command_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] keycode,
  output key_events_t press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [15:0]   raw_q;
  logic [CW-1:0] stable_ctr;
  logic [15:0]   stable_code;
  logic          accept;
  key_events_t   new_keys;
  key_events_t   old_keys;

  assign accept   = (stable_ctr == CNT_LAST);
  assign new_keys = decode_keys(raw_q);
  assign old_keys = decode_keys(stable_code);

  // Sample, count identical samples, accept the code and strobe new presses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q       <= '0;
      stable_ctr  <= '0;
      stable_code <= '0;
      press       <= '0;
    end else begin
      raw_q <= keycode;
      if (keycode == raw_q) begin
        if (stable_ctr != CNT_LAST) stable_ctr <= stable_ctr + CW'(1);
      end else begin
        stable_ctr <= '0;
      end
      if (accept) begin
        stable_code <= raw_q;
        press       <= key_events_t'(new_keys & ~old_keys);
      end else begin
        press <= '0;
      end
    end
  end

endmodule

// File: rtl/sim_command_unit.sv
// Keyboard command front end for the ant simulation: debounced key presses
// drive a run/pause/step/reset FSM and a speed level that selects the
// game-clock slowdown factor.
module sim_command_unit
  import sim_command_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RESET_LEN       = 16,
  parameter int BASE_FACTOR     = 4000000,
  parameter int DEFAULT_LEVEL   = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  input  logic        sweep_done,
  output logic        run,
  output logic        sim_reset,
  output logic [2:0]  speed_level,
  output logic [22:0] slowdown_factor,
  output logic [1:0]  state_o
);

  localparam int RCW = (RESET_LEN > 2) ? $clog2(RESET_LEN) : 1;
  localparam logic [RCW-1:0] RST_LAST  = RCW'(RESET_LEN - 1);
  localparam logic [22:0]    BASE_F    = 23'(BASE_FACTOR);
  localparam logic [2:0]     DEF_LEVEL = 3'(DEFAULT_LEVEL);

  sim_cmd_state_t state;
  key_events_t    press;
  logic [RCW-1:0] rst_cnt;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (Clk),
    .rst    (Reset),
    .keycode(keycode),
    .press  (press)
  );

  assign state_o = state;

  // Command FSM; run and sim_reset are registered alongside the state.
  // Within one event R beats Space beats S; in STEPPING, Space beats sweep_done.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_PAUSED;
      run       <= 1'b0;
      sim_reset <= 1'b0;
      rst_cnt   <= '0;
    end else begin
      case (state)
        ST_PAUSED: begin
          if (press.reset) begin
            state     <= ST_RESETTING;
            run       <= 1'b0;
            sim_reset <= 1'b1;
            rst_cnt   <= '0;
          end else if (press.space) begin
            state <= ST_RUNNING;
            run   <= 1'b1;
          end else if (press.step) begin
            state <= ST_STEPPING;
            run   <= 1'b1;
          end
        end
        ST_RUNNING: begin
          if (press.reset) begin
            state     <= ST_RESETTING;
            run       <= 1'b0;
            sim_reset <= 1'b1;
            rst_cnt   <= '0;
          end else if (press.space) begin
            state <= ST_PAUSED;
            run   <= 1'b0;
          end
        end
        ST_STEPPING: begin
          if (press.reset) begin
            state     <= ST_RESETTING;
            run       <= 1'b0;
            sim_reset <= 1'b1;
            rst_cnt   <= '0;
          end else if (press.space) begin
            state <= ST_RUNNING;
            run   <= 1'b1;
          end else if (sweep_done) begin
            state <= ST_PAUSED;
            run   <= 1'b0;
          end
        end
        ST_RESETTING: begin
          // Keys are ignored; leave after RESET_LEN cycles in this state
          if (rst_cnt == RST_LAST) begin
            state     <= ST_PAUSED;
            run       <= 1'b0;
            sim_reset <= 1'b0;
            rst_cnt   <= '0;
          end else begin
            rst_cnt <= rst_cnt + RCW'(1);
          end
        end
        default: begin
          state     <= ST_PAUSED;
          run       <= 1'b0;
          sim_reset <= 1'b0;
          rst_cnt   <= '0;
        end
      endcase
    end
  end

  // Speed level (saturating, frozen while resetting) and its slowdown factor,
  // which follows the level one cycle later
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      speed_level     <= DEF_LEVEL;
      slowdown_factor <= BASE_F >> DEF_LEVEL;
    end else begin
      slowdown_factor <= BASE_F >> speed_level;
      if (state != ST_RESETTING) begin
        if (press.faster && !press.slower && (speed_level != MAX_LEVEL)) begin
          speed_level <= speed_level + 3'd1;
        end else if (press.slower && !press.faster && (speed_level != 3'd0)) begin
          speed_level <= speed_level - 3'd1;
        end
      end
    end
  end

endmodule
